vadd_ctrl_s_axi: RTL and testbench
==================================

Name: vadd_ctrl_s_axi

Overview:
- AXI4-Lite responder (slave) for the Vadd kernel control register file; the host is the initiator.
- Decodes host reads and writes into ap_start and the kernel arguments A, B and scalar00, which drive the kernel top wrapper.
- Reflects the kernel's ap_done, ap_idle and ap_ready back to the host and raises an optional interrupt.

Parameters:
C_S_AXI_ADDR_WIDTH, 12, address bits decoded; upper bits are ignored.
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.

Ports:
ap_clk  in  1  single clock for the bus and all registers
ap_rst_n  in  1  asynchronous active-low reset
s_axi_awvalid/awready  in/out  1/1  write address handshake
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_wvalid/wready  in/out  1/1  write data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_bvalid/bready  out/in  1/1  write response handshake
s_axi_bresp  out  2  always 2'b00 (OKAY)
s_axi_arvalid/arready  in/out  1/1  read address handshake
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_rvalid/rready  out/in  1/1  read data handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00 (OKAY)
ap_start  out  1  kernel start level
ap_done  in  1  kernel done pulse
ap_idle  in  1  kernel idle level
ap_ready  in  1  kernel ready pulse
scalar00  out  32  scalar argument
A  out  64  buffer A address
B  out  64  buffer B address
interrupt  out  1  level interrupt

Behaviour:
- Register map (word aligned; addr[1:0] ignored):
  - 0x00 CTRL: bit0 ap_start (R/W), bit1 done (R, clear-on-read), bit2 idle (R, live), bit3 ready (R, live), bit7 auto_restart (R/W).
  - 0x04 GIE: bit0 global interrupt enable.
  - 0x08 IER: bit0 done enable, bit1 ready enable.
  - 0x0C ISR: bit0 done status, bit1 ready status; writing 1 toggles the bit.
  - 0x10 scalar00.
  - 0x18 A[31:0], 0x1C A[63:32].
  - 0x24 B[31:0], 0x28 B[63:32].
  - Any other address: reads return 0, writes are dropped, response is still OKAY.
- Reset values:
  - All registers 0.
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rdata=0.
  - ap_start=0, interrupt=0.
- Write FSM, states WIDLE, WDATA, WRESP:
  - WIDLE: awready=1. On awvalid, latch the address and go to WDATA.
  - WDATA: wready=1. On wvalid, commit the write with per-byte wstrb masking and go to WRESP.
  - WRESP: bvalid=1. On bready, go to WIDLE.
  - One write is outstanding at a time; W presented before AW is held off by wready=0.
- Read FSM, states RIDLE, RDATA:
  - RIDLE: arready=1. On arvalid, capture rdata on the next edge and go to RDATA.
  - RDATA: rvalid=1. rdata is held stable until rready, then go to RIDLE.
  - Read latency: rvalid asserts 1 cycle after the AR handshake.
- ap_start:
  - Set by a write of 1 to CTRL bit0; a write of 0 has no effect.
  - Cleared the cycle after ap_ready=1, unless auto_restart=1.
- done bit:
  - Set on ap_done=1.
  - Cleared when a CTRL read is accepted (AR handshake), unless ap_done=1 in the same cycle; set wins.
- ISR:
  - bit0 set when ap_done & IER[0]; bit1 set when ap_ready & IER[1].
  - If a hardware set and a host toggle hit the same cycle, the bit ends at 1.
- Read and write FSMs are independent; simultaneous read and write to the same register returns the pre-write value.
- Reset mid-transaction: every FSM returns to idle and every register returns to 0; the in-flight response is lost.

Optional Feature:
VADD_CTRL_IRQ_EN
- Defined: GIE, IER and ISR are implemented; interrupt = GIE[0] & (ISR[0] | ISR[1]), registered with 1-cycle latency.
- Undefined: 0x04, 0x08 and 0x0C read 0 and ignore writes; interrupt is tied to 0.

Test Plan:
- Write 0x18=0x1000_0000 and 0x1C=0x0000_0001, wstrb=4'hF -> A=64'h0000_0001_1000_0000; each bresp=OKAY; 0x18 reads back 0x1000_0000.
- Write 0x10=0xAABBCCDD with wstrb=4'b0011 over an old value of 0 -> scalar00=0x0000CCDD.
- Write CTRL=1, then pulse ap_ready and ap_done for 1 cycle -> ap_start goes 1 then 0. First CTRL read returns bit1=1; second read returns bit1=0.
- Set auto_restart (CTRL=0x81), then pulse ap_ready -> ap_start stays 1.
- With VADD_CTRL_IRQ_EN defined: GIE=1, IER=1, pulse ap_done -> ISR=1 and interrupt=1 after 1 cycle. Write ISR=1 -> ISR=0 and interrupt=0.
- Hold rready=0 for 5 cycles after reading 0x24 -> rvalid stays 1 and rdata stays stable; then assert rready with ap_rst_n dropping in the same cycle -> rvalid=0 and all registers 0.

Source files
------------

// File: rtl/vadd_ctrl_s_axi.sv
// vadd_ctrl_s_axi: AXI4-Lite control registers for Vadd (ap_ctrl, A, B, scalar00); VADD_CTRL_IRQ_EN adds GIE/IER/ISR and the interrupt.
// Latency: writes commit on the W beat, read data is valid 1 cycle after the AR handshake; one transaction per channel in flight.
// Backpressure: wready stays low until AW is accepted; bvalid/rvalid and rdata hold until bready/rready.
module vadd_ctrl_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    output logic [1:0]                      s_axi_bresp,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    input  logic                            ap_ready,
    output logic [31:0]                     scalar00,
    output logic [63:0]                     A,
    output logic [63:0]                     B,
    output logic                            interrupt
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    localparam logic [AW-1:0] ALIGN       = AW'(6'h03);
    localparam logic [AW-1:0] ADDR_CTRL   = AW'(6'h00);
    localparam logic [AW-1:0] ADDR_SCALAR = AW'(6'h10);
    localparam logic [AW-1:0] ADDR_A_LO   = AW'(6'h18);
    localparam logic [AW-1:0] ADDR_A_HI   = AW'(6'h1C);
    localparam logic [AW-1:0] ADDR_B_LO   = AW'(6'h24);
    localparam logic [AW-1:0] ADDR_B_HI   = AW'(6'h28);
`ifdef VADD_CTRL_IRQ_EN
    localparam logic [AW-1:0] ADDR_GIE    = AW'(6'h04);
    localparam logic [AW-1:0] ADDR_IER    = AW'(6'h08);
    localparam logic [AW-1:0] ADDR_ISR    = AW'(6'h0C);
`endif

    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
    typedef enum logic {RIDLE, RDATA} rstate_t;

    wstate_t        wstate;
    rstate_t        rstate;
    logic [AW-1:0]  waddr;
    logic [AW-1:0]  wsel;
    logic [AW-1:0]  rsel;
    logic           w_hs;
    logic           ar_hs;
    logic           wr_ctrl;
    logic           auto_restart;
    logic           done;
    logic [31:0]    rd_val;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    assign wsel    = waddr & ~ALIGN;
    assign rsel    = s_axi_araddr & ~ALIGN;
    assign w_hs    = s_axi_wready & s_axi_wvalid;
    assign ar_hs   = s_axi_arready & s_axi_arvalid;
    assign wr_ctrl = w_hs && (wsel == ADDR_CTRL) && s_axi_wstrb[0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (d & m) | (old & ~m);
    endfunction

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wstate        <= WIDLE;
            waddr         <= '0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            case (wstate)
                WIDLE: if (s_axi_awvalid) begin
                    waddr         <= s_axi_awaddr;
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b1;
                    wstate        <= WDATA;
                end
                WDATA: if (s_axi_wvalid) begin
                    s_axi_wready <= 1'b0;
                    s_axi_bvalid <= 1'b1;
                    wstate       <= WRESP;
                end
                WRESP: if (s_axi_bready) begin
                    s_axi_bvalid  <= 1'b0;
                    s_axi_awready <= 1'b1;
                    wstate        <= WIDLE;
                end
                default: begin
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    wstate        <= WIDLE;
                end
            endcase
        end
    end

    // rdata is captured at the AR edge, so a write committing on that same edge is not yet visible
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rstate        <= RIDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            case (rstate)
                RIDLE: if (s_axi_arvalid) begin
                    s_axi_rdata   <= rd_val;
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b1;
                    rstate        <= RDATA;
                end
                RDATA: if (s_axi_rready) begin
                    s_axi_rvalid  <= 1'b0;
                    s_axi_arready <= 1'b1;
                    rstate        <= RIDLE;
                end
                default: begin
                    s_axi_rvalid  <= 1'b0;
                    s_axi_arready <= 1'b1;
                    rstate        <= RIDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            scalar00 <= '0;
            A        <= '0;
            B        <= '0;
        end else if (w_hs) begin
            case (wsel)
                ADDR_SCALAR: scalar00  <= merge(scalar00, s_axi_wdata, s_axi_wstrb);
                ADDR_A_LO:   A[31:0]   <= merge(A[31:0], s_axi_wdata, s_axi_wstrb);
                ADDR_A_HI:   A[63:32]  <= merge(A[63:32], s_axi_wdata, s_axi_wstrb);
                ADDR_B_LO:   B[31:0]   <= merge(B[31:0], s_axi_wdata, s_axi_wstrb);
                ADDR_B_HI:   B[63:32]  <= merge(B[63:32], s_axi_wdata, s_axi_wstrb);
                default: ;
            endcase
        end
    end

    // A host start wins over a same-cycle ap_ready; done set wins over clear-on-read
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start     <= 1'b0;
            auto_restart <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (wr_ctrl && s_axi_wdata[0])
                ap_start <= 1'b1;
            else if (ap_ready)
                ap_start <= auto_restart;
            if (wr_ctrl)
                auto_restart <= s_axi_wdata[7];
            if (ap_done)
                done <= 1'b1;
            else if (ar_hs && (rsel == ADDR_CTRL))
                done <= 1'b0;
        end
    end

`ifdef VADD_CTRL_IRQ_EN
    logic       gie;
    logic [1:0] ier;
    logic [1:0] isr;
    logic [1:0] isr_set;
    logic [1:0] isr_tgl;

    always_comb begin
        isr_set = {ap_ready & ier[1], ap_done & ier[0]};
        isr_tgl = 2'b00;
        if (w_hs && (wsel == ADDR_ISR) && s_axi_wstrb[0])
            isr_tgl = s_axi_wdata[1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gie       <= 1'b0;
            ier       <= 2'b00;
            isr       <= 2'b00;
            interrupt <= 1'b0;
        end else begin
            if (w_hs && (wsel == ADDR_GIE) && s_axi_wstrb[0])
                gie <= s_axi_wdata[0];
            if (w_hs && (wsel == ADDR_IER) && s_axi_wstrb[0])
                ier <= s_axi_wdata[1:0];
            isr       <= isr_set | (isr ^ isr_tgl);
            interrupt <= gie & (|isr);
        end
    end
`else
    assign interrupt = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (rsel)
            ADDR_CTRL:   rd_val = {24'd0, auto_restart, 3'd0, ap_ready, ap_idle, done, ap_start};
`ifdef VADD_CTRL_IRQ_EN
            ADDR_GIE:    rd_val = {31'd0, gie};
            ADDR_IER:    rd_val = {30'd0, ier};
            ADDR_ISR:    rd_val = {30'd0, isr};
`endif
            ADDR_SCALAR: rd_val = scalar00;
            ADDR_A_LO:   rd_val = A[31:0];
            ADDR_A_HI:   rd_val = A[63:32];
            ADDR_B_LO:   rd_val = B[31:0];
            ADDR_B_HI:   rd_val = B[63:32];
            default:     rd_val = '0;
        endcase
    end
endmodule

// File: tb/tb_vadd_ctrl_s_axi.sv
// Bench for vadd_ctrl_s_axi: vector table, hand-written control/interrupt/reset sequences, randomized traffic vs a register-map model.
`timescale 1ns/1ps
module tb_vadd_ctrl_s_axi;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        s_axi_awvalid = 0, s_axi_awready;
    logic [11:0] s_axi_awaddr = '0;
    logic        s_axi_wvalid = 0, s_axi_wready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_bvalid, s_axi_bready = 0;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid = 0, s_axi_arready;
    logic [11:0] s_axi_araddr = '0;
    logic        s_axi_rvalid, s_axi_rready = 0;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        ap_start, ap_done = 0, ap_idle = 0, ap_ready = 0;
    logic [31:0] scalar00;
    logic [63:0] A, B;
    logic        interrupt;

    always #5 ap_clk = ~ap_clk;

    vadd_ctrl_s_axi #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .scalar00(scalar00), .A(A), .B(B), .interrupt(interrupt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        failures++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    // Register-map model, kept as plain values per host-visible field
    logic [31:0] m_scalar, m_alo, m_ahi, m_blo, m_bhi;
    bit          m_start, m_auto, m_done, m_gie;
    bit [1:0]    m_ier, m_isr;

    task automatic model_reset();
        m_scalar = 0; m_alo = 0; m_ahi = 0; m_blo = 0; m_bhi = 0;
        m_start = 0; m_auto = 0; m_done = 0; m_gie = 0; m_ier = 0; m_isr = 0;
    endtask

    function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] addr);
        case (addr >> 2)
            0:  return {24'd0, m_auto, 3'd0, ap_ready, ap_idle, m_done, m_start};
`ifdef VADD_CTRL_IRQ_EN
            1:  return {31'd0, m_gie};
            2:  return {30'd0, m_ier};
            3:  return {30'd0, m_isr};
`endif
            4:  return m_scalar;
            6:  return m_alo;
            7:  return m_ahi;
            9:  return m_blo;
            10: return m_bhi;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] s);
        case (addr >> 2)
            0: if (s[0]) begin
                if (d[0]) m_start = 1;
                m_auto = d[7];
            end
`ifdef VADD_CTRL_IRQ_EN
            1: if (s[0]) m_gie = d[0];
            2: if (s[0]) m_ier = d[1:0];
            3: if (s[0]) m_isr = m_isr ^ d[1:0];
`endif
            4:  m_scalar = bytes_merge(m_scalar, d, s);
            6:  m_alo = bytes_merge(m_alo, d, s);
            7:  m_ahi = bytes_merge(m_ahi, d, s);
            9:  m_blo = bytes_merge(m_blo, d, s);
            10: m_bhi = bytes_merge(m_bhi, d, s);
            default: ;
        endcase
    endtask

    function automatic bit model_irq();
`ifdef VADD_CTRL_IRQ_EN
        return m_gie & (|m_isr);
`else
        return 1'b0;
`endif
    endfunction

    // All bus tasks are entered and left 1 ns after a rising edge
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit rdy_pulse, output logic [1:0] resp);
        int n;
        resp = 2'b11;
        s_axi_awaddr = addr; s_axi_awvalid = 1;
        n = 0;
        while (!s_axi_awready && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (n == 20) timed_out("aw_handshake");
        @(posedge ap_clk); #1;
        s_axi_awvalid = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1; ap_ready = rdy_pulse;
        n = 0;
        while (!s_axi_wready && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (n == 20) timed_out("w_handshake");
        @(posedge ap_clk); #1;
        s_axi_wvalid = 0; ap_ready = 0;
        s_axi_bready = 1;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (n == 20) timed_out("b_handshake");
        resp = s_axi_bresp;
        @(posedge ap_clk); #1;
        s_axi_bready = 0;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        s_axi_araddr = addr; s_axi_arvalid = 1;
        n = 0;
        while (!s_axi_arready && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (n == 20) timed_out("ar_handshake");
        @(posedge ap_clk); #1;
        s_axi_arvalid = 0;
        check("r_latency", s_axi_rvalid, 1);
        n = 0;
        while (!s_axi_rvalid && n < 20) begin @(posedge ap_clk); #1; n++; end
        data = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1;
        @(posedge ap_clk); #1;
        s_axi_rready = 0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, 1'b0, r);
        check("bresp", r, 2'b00);
    endtask

    task automatic rd_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(name, d, exp);
        check({name, "_rresp"}, r, 2'b00);
    endtask

    task automatic pulse(input bit done_p, input bit ready_p);
        ap_done = done_p; ap_ready = ready_p;
        @(posedge ap_clk); #1;
        ap_done = 0; ap_ready = 0;
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[10];
    logic [11:0] pool[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, exp;
        logic [11:0] a;
        logic [3:0]  s;
        logic [1:0]  r;

        tbl[0] = '{12'h018, 32'h1000_0000, 4'hF, 32'h1000_0000};
        tbl[1] = '{12'h01C, 32'h0000_0001, 4'hF, 32'h0000_0001};
        tbl[2] = '{12'h010, 32'hAABB_CCDD, 4'b0011, 32'h0000_CCDD};
        tbl[3] = '{12'h024, 32'h1234_5678, 4'hF, 32'h1234_5678};
        tbl[4] = '{12'h028, 32'hDEAD_BEEF, 4'b1100, 32'hDEAD_0000};
        tbl[5] = '{12'h02A, 32'h0000_BEEF, 4'b0011, 32'hDEAD_BEEF};
        tbl[6] = '{12'h030, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        tbl[7] = '{12'h410, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        tbl[8] = '{12'h014, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        tbl[9] = '{12'h020, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        pool = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                 12'h018, 12'h01C, 12'h024, 12'h028, 12'h02C, 12'h810};

        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_awready", s_axi_awready, 1);
        check("rst_arready", s_axi_arready, 1);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_ap_start", ap_start, 0);
        check("rst_interrupt", interrupt, 0);
        check("rst_regs", A | B | {32'd0, scalar00}, 0);
        ap_rst_n = 1;
        @(posedge ap_clk); #1;

        for (int i = 0; i < 10; i++) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0, r);
            check($sformatf("tbl%0d_bresp", i), r, 2'b00);
            rd_check($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].exp);
        end
        check("tbl_A", A, 64'h0000_0001_1000_0000);
        check("tbl_B", B, 64'hDEAD_BEEF_1234_5678);
        check("tbl_scalar00", scalar00, 32'h0000_CCDD);

        // W before AW must be held off
        s_axi_wdata = 32'h5555_5555; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("w_before_aw_wready", s_axi_wready, 0);
        s_axi_wvalid = 0;
        check("w_before_aw_scalar", scalar00, 32'h0000_CCDD);

        // ap_start handshake and clear-on-read done
        wr(12'h000, 32'h1);
        check("start_set", ap_start, 1);
        pulse(1, 1);
        check("start_clr_on_ready", ap_start, 0);
        rd_check("ctrl_rd1", 12'h000, 32'h2);
        rd_check("ctrl_rd2", 12'h000, 32'h0);

        ap_done = 1;
        @(posedge ap_clk); #1;
        rd_check("done_wins_rd1", 12'h000, 32'h2);
        ap_done = 0;
        rd_check("done_wins_rd2", 12'h000, 32'h2);
        rd_check("done_wins_rd3", 12'h000, 32'h0);

        ap_idle = 1;
        rd_check("idle_live", 12'h000, 32'h4);
        ap_idle = 0;

        wr(12'h000, 32'h81);
        check("auto_start", ap_start, 1);
        pulse(0, 1);
        @(posedge ap_clk); #1;
        check("auto_hold", ap_start, 1);
        rd_check("auto_rd", 12'h000, 32'h81);
        wr(12'h000, 32'h0);
        check("write0_no_effect", ap_start, 1);
        rd_check("auto_off_rd", 12'h000, 32'h1);
        pulse(0, 1);
        check("start_clr_no_auto", ap_start, 0);

`ifdef VADD_CTRL_IRQ_EN
        wr(12'h004, 32'h1);
        wr(12'h008, 32'h1);
        pulse(1, 0);
        check("irq_lat0", interrupt, 0);
        @(posedge ap_clk); #1;
        check("irq_lat1", interrupt, 1);
        rd_check("isr_set", 12'h00C, 32'h1);
        wr(12'h00C, 32'h1);
        rd_check("isr_toggle_clr", 12'h00C, 32'h0);
        check("irq_clr", interrupt, 0);
        wr(12'h008, 32'h3);
        pulse(0, 1);
        rd_check("isr_ready_set", 12'h00C, 32'h2);
        axi_write(12'h00C, 32'h2, 4'hF, 1'b1, r);
        rd_check("isr_set_wins", 12'h00C, 32'h2);
        wr(12'h00C, 32'h2);
        rd_check("isr_toggle2", 12'h00C, 32'h0);
        wr(12'h004, 32'h0);
        pulse(1, 0);
        repeat (2) @(posedge ap_clk);
        #1;
        check("irq_gie_off", interrupt, 0);
        rd_check("gie_rd", 12'h004, 32'h0);
        rd_check("ier_rd", 12'h008, 32'h3);
`else
        wr(12'h004, 32'hFFFF_FFFF);
        wr(12'h008, 32'hFFFF_FFFF);
        wr(12'h00C, 32'hFFFF_FFFF);
        pulse(1, 1);
        rd_check("gie_absent", 12'h004, 32'h0);
        rd_check("ier_absent", 12'h008, 32'h0);
        rd_check("isr_absent", 12'h00C, 32'h0);
        check("irq_absent", interrupt, 0);
`endif

        // Read held by rready=0, then reset lands with rready
        s_axi_araddr = 12'h024; s_axi_arvalid = 1;
        @(posedge ap_clk); #1;
        s_axi_arvalid = 0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d_rvalid", c), s_axi_rvalid, 1);
            check($sformatf("hold%0d_rdata", c), s_axi_rdata, 32'h1234_5678);
            @(posedge ap_clk); #1;
        end
        s_axi_rready = 1; ap_rst_n = 0;
        #1;
        check("mid_rst_rvalid", s_axi_rvalid, 0);
        check("mid_rst_rdata", s_axi_rdata, 0);
        check("mid_rst_regs", A | B | {32'd0, scalar00}, 0);
        check("mid_rst_start", ap_start, 0);
        check("mid_rst_arready", s_axi_arready, 1);
        @(posedge ap_clk); #1;
        s_axi_rready = 0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1;
        @(posedge ap_clk); #1;
        rd_check("post_rst_b", 12'h024, 32'h0);
        rd_check("post_rst_ctrl", 12'h000, 32'h0);

        model_reset();
        for (int i = 0; i < 300; i++) begin
            a = pool[$urandom_range(0, 11)] | 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, 1'b0, r);
                model_write(a, d, s);
                check("rnd_bresp", r, 2'b00);
                check("rnd_A", A, {m_ahi, m_alo});
                check("rnd_B", B, {m_bhi, m_blo});
                check("rnd_scalar00", scalar00, m_scalar);
                check("rnd_ap_start", ap_start, m_start);
                check("rnd_interrupt", interrupt, model_irq());
            end else begin
                ap_idle = 1'($urandom_range(0, 1));
                exp = model_read(a);
                axi_read(a, d, r);
                if ((a >> 2) == 0) m_done = 0;
                check($sformatf("rnd_rd_%03h", a), d, exp);
                check("rnd_rresp", r, 2'b00);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
